kernel_wload: RTL
=================

// Module: kernel_wload
// PURPOSE
//  Write-side companion of the kernel weight mux. Accepts a stream of directional
//  kernel weights over a valid/ready handshake and stores them into eight weight
//  registers in select-code order (1=tl,2=tr,3=bl,4=br,5=r,6=l,7=t,8=b).
//  The registers drive the mux weight inputs directly.
//  Sits between the weight source (host/ROM sequencer) and the kernel weight mux.
// PARAMETERS
//  W_WIDTH    3   width of one directional weight
//  SEL_WIDTH  4   width of select code (codes 1..8 used, 0 = none)
// PORTS
//  clk           in   1          system clock, all logic on rising edge
//  rst           in   1          synchronous, active-high reset
//  start         in   1          begin loading a new 8-weight kernel (sampled in IDLE only)
//  abort         in   1          cancel an in-progress load
//  in_valid      in   1          in_w carries a weight
//  in_ready      out  1          block accepts a weight this cycle (registered)
//  in_w          in   W_WIDTH    incoming weight value
//  wr_sel        out  SEL_WIDTH  select code the next accepted weight is written to; 0 when idle
//  tl_w,tr_w,bl_w,br_w,r_w,l_w,t_w,b_w  out  W_WIDTH each  stored weights
//  busy          out  1          high in LOAD
//  done          out  1          1-cycle pulse: full kernel loaded
//  kernel_valid  out  1          level: all 8 registers hold one complete kernel
// BEHAVIOUR
//  Reset: all weight regs=0, wr_sel=0, in_ready=0, busy=0, done=0, kernel_valid=0, state=IDLE.
//  FSM states: IDLE, LOAD, FIN.
//  IDLE: in_ready=0, wr_sel=0.
//   - start&!abort -> LOAD next cycle; wr_sel=1, in_ready=1, busy=1, kernel_valid=0.
//   - start&abort -> remain in IDLE.
//  LOAD: a beat transfers on (in_valid & in_ready).
//   - On transfer, the register addressed by wr_sel is written with in_w;
//     wr_sel increments by 1. No other register changes.
//   - in_valid without in_ready: no write.
//   - Transfer with wr_sel==8 -> FIN next cycle; in_ready=0, wr_sel=0.
//   - start in LOAD: ignored.
//   - abort (has priority over a same-cycle transfer; that beat is NOT written)
//     -> IDLE next cycle. Effects:
//       - in_ready=0, busy=0, wr_sel=0, kernel_valid stays 0.
//       - Partially written regs keep their values.
//  FIN: exactly one cycle; done=1, kernel_valid=1, busy=0, then IDLE.
//   - start/abort during FIN: ignored.
//  kernel_valid holds 1 until the next accepted start (cleared when entering LOAD) or reset.
//  Latency:
//   - start to first in_ready: 1 cycle.
//   - 8th transfer to done: 1 cycle.
//   - Minimum load: start + 8 beats + 1 = 10 cycles.
//  Outputs are registered; no combinational path from in_valid to in_ready.
//  rst mid-load forces the full reset state on the next edge regardless of other inputs.
// TESTING
//  1. Reset, start, in_valid=1 every cycle, in_w=1..7,0 ->
//     tl=1,tr=2,bl=3,br=4,r=5,l=6,t=7,b=0; done pulse 1 cycle after 8th beat;
//     kernel_valid=1.
//  2. Same data with in_valid toggling 1/0 ->
//     identical register contents; wr_sel steps 1..8 only on transfers;
//     done 1 cycle after 8th transfer.
//  3. Load 7s fully, start again, send 2 beats of 3, assert abort ->
//     tl=tr=3, others 7; kernel_valid=0; IDLE; 3rd beat (if presented with abort) not written.
//  4. start while in LOAD and during FIN cycle ->
//     no restart, wr_sel sequence unaffected; start&abort in IDLE -> stays IDLE.
//  5. rst asserted after 4 beats -> next cycle: all regs 0, in_ready=0, wr_sel=0, kernel_valid=0.
//  6. Back-to-back kernels (start in cycle after FIN) ->
//     kernel_valid drops when LOAD entered; second kernel fully overwrites first.

Source files
------------

// File: rtl/kernel_wload.sv
// Write-side loader for the kernel weight mux: streams eight directional weights
// over valid/ready into registers addressed by select code 1..8.
module kernel_wload #(
    parameter int unsigned W_WIDTH   = 3,
    parameter int unsigned SEL_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W_WIDTH-1:0]   in_w,
    output logic [SEL_WIDTH-1:0] wr_sel,
    output logic [W_WIDTH-1:0]   tl_w,
    output logic [W_WIDTH-1:0]   tr_w,
    output logic [W_WIDTH-1:0]   bl_w,
    output logic [W_WIDTH-1:0]   br_w,
    output logic [W_WIDTH-1:0]   r_w,
    output logic [W_WIDTH-1:0]   l_w,
    output logic [W_WIDTH-1:0]   t_w,
    output logic [W_WIDTH-1:0]   b_w,
    output logic                 busy,
    output logic                 done,
    output logic                 kernel_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic [SEL_WIDTH-1:0] wr_sel_q, wr_sel_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 kv_q, kv_d;
    logic [W_WIDTH-1:0]   w_q [8];
    logic [W_WIDTH-1:0]   w_d [8];
    logic [2:0]           wr_idx;
    logic                 xfer;

    // Select code 1..8 maps onto register slots 0..7.
    assign wr_idx = 3'(wr_sel_q - SEL_WIDTH'(1));
    assign xfer   = in_valid & in_ready_q;

    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        wr_sel_d   = wr_sel_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        kv_d       = kv_q;
        w_d        = w_q;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = LOAD;
                    wr_sel_d   = SEL_WIDTH'(1);
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    kv_d       = 1'b0;
                end
            end
            LOAD: begin
                // Abort wins over a same-cycle transfer; that beat is dropped.
                if (abort) begin
                    state_d    = IDLE;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b0;
                    wr_sel_d   = '0;
                end else if (xfer) begin
                    w_d[wr_idx] = in_w;
                    if (wr_sel_q == SEL_WIDTH'(8)) begin
                        state_d    = FIN;
                        in_ready_d = 1'b0;
                        wr_sel_d   = '0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        kv_d       = 1'b1;
                    end else begin
                        wr_sel_d = wr_sel_q + SEL_WIDTH'(1);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            wr_sel_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            kv_q       <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            wr_sel_q   <= wr_sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            kv_q       <= kv_d;
            for (int unsigned i = 0; i < 8; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign wr_sel       = wr_sel_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign kernel_valid = kv_q;
    assign tl_w         = w_q[0];
    assign tr_w         = w_q[1];
    assign bl_w         = w_q[2];
    assign br_w         = w_q[3];
    assign r_w          = w_q[4];
    assign l_w          = w_q[5];
    assign t_w          = w_q[6];
    assign b_w          = w_q[7];

endmodule
